i_format_encoder_loader: RTL and testbench

- Turns I-format operation requests (op, Rd, Rn, immediate) into 32-bit LEGv8 I-format instruction words and writes them sequentially into instruction memory.
- It is the encode side of the I-format decode path: the decode path reads opcode bits [31:22], ALUImm [21:10], Rn [9:5] and Rd [4:0] back out of words this block writes.
- Used by the boot/test program loader to fill instruction RAM before the CPU is released.

---
 rtl/i_format_encoder_loader.sv | 150 +++++++++++++++
 tb/tb_i_format_encoder_loader.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/i_format_encoder_loader.sv
// Encodes LEGv8 I-format requests (op, Rd, Rn, imm) into 32-bit instruction words
// and writes them sequentially into instruction RAM for the boot/test loader.
module i_format_encoder_loader #(
  parameter int unsigned           ADDR_WIDTH = 64,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int unsigned           DEPTH      = 256
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            op,
  input  logic [4:0]            rd,
  input  logic [4:0]            rn,
  input  logic [63:0]           k,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_data,
  output logic [15:0]           count,
  output logic                  full,
  output logic                  err
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned IMM_W = 12;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ENCODE = 2'd1,
    S_WRITE  = 2'd2,
    S_FULL   = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic                    r_in_ready;
  logic                    r_wr;
  logic                    r_full;
  logic [2:0]              r_op;
  logic [4:0]              r_rd;
  logic [4:0]              r_rn;
  logic [IMM_W-1:0]        r_imm;
  logic                    r_k_oor;
  logic [ADDR_WIDTH-1:0]   r_mem_addr;
  logic [31:0]             r_mem_data;
  logic [CNT_W-1:0]        r_count;
  logic                    r_err;
  logic                    w_accept;
  logic [CNT_W-1:0]        w_count_inc;
  logic                    w_last;

  // 10-bit opcode field for each of the eight I-format operations
  function automatic logic [9:0] opc(input logic [2:0] o);
    case (o)
      3'd0:    opc = 10'h244;
      3'd1:    opc = 10'h2C4;
      3'd2:    opc = 10'h344;
      3'd3:    opc = 10'h3C4;
      3'd4:    opc = 10'h248;
      3'd5:    opc = 10'h3C8;
      3'd6:    opc = 10'h2C8;
      default: opc = 10'h348;
    endcase
  endfunction

  assign w_accept    = in_valid & r_in_ready & ~clear;
  assign w_count_inc = r_count + CNT_W'(1);
  assign w_last      = (w_count_inc == CNT_W'(DEPTH));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_next = S_ENCODE;
      S_ENCODE: w_next = r_k_oor ? S_IDLE : S_WRITE;
      S_WRITE:  w_next = w_last ? S_FULL : S_IDLE;
      S_FULL:   w_next = S_FULL;
      default:  w_next = S_IDLE;
    endcase
    if (clear) w_next = S_IDLE;
  end

  // State-decoded outputs, registered from the next state so they track r_state
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_in_ready <= 1'b0;
      r_wr       <= 1'b0;
      r_full     <= 1'b0;
    end else begin
      r_in_ready <= (w_next == S_IDLE);
      r_wr       <= (w_next == S_WRITE);
      r_full     <= (w_next == S_FULL);
    end
  end

  // Request hold register; only the out-of-range verdict of the upper immediate bits is kept
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_op    <= '0;
      r_rd    <= '0;
      r_rn    <= '0;
      r_imm   <= '0;
      r_k_oor <= 1'b0;
    end else if (w_accept) begin
      r_op    <= op;
      r_rd    <= rd;
      r_rn    <= rn;
      r_imm   <= k[IMM_W-1:0];
      r_k_oor <= |k[63:IMM_W];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_mem_addr <= '0;
      r_mem_data <= '0;
    end else if (r_state == S_ENCODE && !clear && !r_k_oor) begin
      r_mem_data <= {opc(r_op), r_imm, r_rn, r_rd};
      r_mem_addr <= BASE_ADDR + ADDR_WIDTH'({r_count, 2'b00});
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
      r_err   <= 1'b0;
    end else if (clear) begin
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      if (r_state == S_WRITE)              r_count <= w_count_inc;
      if (r_state == S_ENCODE && r_k_oor)  r_err   <= 1'b1;
    end
  end

  // clear aborts an in-flight write within the same cycle
  assign mem_write = r_wr & ~clear;
  assign in_ready  = r_in_ready;
  assign full      = r_full;
  assign mem_addr  = r_mem_addr;
  assign mem_data  = r_mem_data;
  assign count     = r_count;
  assign err       = r_err;

endmodule

// File: tb/tb_i_format_encoder_loader.sv
// Directed bench for i_format_encoder_loader: default instance plus a DEPTH=2 instance.
module tb_i_format_encoder_loader;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        clear, in_valid, clear2, in_valid2;
  logic [2:0]  op;
  logic [4:0]  rd, rn;
  logic [63:0] k;
  logic        in_ready, mem_write, full, err;
  logic [63:0] mem_addr;
  logic [31:0] mem_data;
  logic [15:0] count;
  logic        in_ready2, mem_write2, full2, err2;
  logic [63:0] mem_addr2;
  logic [31:0] mem_data2;
  logic [15:0] count2;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [31:0] OPC_W [8] = '{32'h91000000, 32'hB1000000, 32'hD1000000, 32'hF1000000,
                                        32'h92000000, 32'hF2000000, 32'hB2000000, 32'hD2000000};

  always #5 clock = ~clock;

  i_format_encoder_loader u_dut (
    .clock(clock), .reset_n(reset_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .rd(rd), .rn(rn), .k(k), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_data(mem_data), .count(count), .full(full), .err(err));

  i_format_encoder_loader #(.ADDR_WIDTH(64), .BASE_ADDR(64'd0), .DEPTH(2)) u_dut2 (
    .clock(clock), .reset_n(reset_n), .clear(clear2), .in_valid(in_valid2), .in_ready(in_ready2),
    .op(op), .rd(rd), .rn(rn), .k(k), .mem_write(mem_write2), .mem_addr(mem_addr2),
    .mem_data(mem_data2), .count(count2), .full(full2), .err(err2));

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present one request to u_dut and return in the ENCODE cycle
  task automatic do_req(input logic [2:0] o, input logic [4:0] d, input logic [4:0] s, input logic [63:0] kk);
    int w;
    w = 0;
    op = o; rd = d; rn = s; k = kk;
    while (!in_ready && w < 10) begin tick(); w++; end
    if (!in_ready) begin n_cmp++; n_bad++; $display("FAIL req_timeout: in_ready=%b want 1", in_ready); end
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; clear = 1'b0; in_valid = 1'b0; clear2 = 1'b0; in_valid2 = 1'b0;
    op = '0; rd = '0; rn = '0; k = '0;
    tick(); tick();
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    n_cmp++; if ({mem_write, full, err} !== 3'b000) begin n_bad++; $display("FAIL rst_flags: got %b want 000", {mem_write, full, err}); end
    n_cmp++; if (mem_addr !== 64'd0 || mem_data !== 32'd0 || count !== 16'd0) begin n_bad++;
      $display("FAIL rst_data: addr %h data %h count %0d want 0 0 0", mem_addr, mem_data, count); end
    reset_n = 1'b1;
    tick();
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_release_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_addi();
    do_req(3'd0, 5'd1, 5'd2, 64'd5);
    n_cmp++; if (in_ready !== 1'b0 || mem_write !== 1'b0) begin n_bad++; $display("FAIL addi_encode: ready %b wr %b want 0 0", in_ready, mem_write); end
    tick();
    n_cmp++; if (mem_write !== 1'b1 || mem_addr !== 64'd0 || mem_data !== 32'h91001441) begin n_bad++;
      $display("FAIL addi_write: wr %b addr %h data %h want 1 0 91001441", mem_write, mem_addr, mem_data); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL addi_write_ready: got %b want 0", in_ready); end
    tick();
    n_cmp++; if (mem_write !== 1'b0 || count !== 16'd1 || in_ready !== 1'b1 || mem_data !== 32'h91001441) begin n_bad++;
      $display("FAIL addi_after: wr %b count %0d ready %b data %h want 0 1 1 91001441", mem_write, count, in_ready, mem_data); end
  endtask

  task automatic test_clear_idle();
    clear = 1'b1; in_valid = 1'b1;
    tick();
    clear = 1'b0; in_valid = 1'b0;
    n_cmp++; if (count !== 16'd0 || in_ready !== 1'b1) begin n_bad++;
      $display("FAIL clear_idle: count %0d ready %b want 0 1", count, in_ready); end
    tick();
    n_cmp++; if (mem_write !== 1'b0 || in_ready !== 1'b1) begin n_bad++;
      $display("FAIL clear_idle_noaccept: wr %b ready %b want 0 1", mem_write, in_ready); end
  endtask

  task automatic test_back_to_back();
    do_req(3'd7, 5'd31, 5'd0, 64'hFFF);
    tick();
    n_cmp++; if (mem_write !== 1'b1 || mem_addr !== 64'd0 || mem_data !== 32'hD23FFC1F) begin n_bad++;
      $display("FAIL eori_write: wr %b addr %h data %h want 1 0 d23ffc1f", mem_write, mem_addr, mem_data); end
    tick();
    do_req(3'd3, 5'd3, 5'd4, 64'd1);
    tick();
    n_cmp++; if (mem_write !== 1'b1 || mem_addr !== 64'd4 || mem_data !== 32'hF1000483) begin n_bad++;
      $display("FAIL subis_write: wr %b addr %h data %h want 1 4 f1000483", mem_write, mem_addr, mem_data); end
    tick();
    n_cmp++; if (count !== 16'd2) begin n_bad++; $display("FAIL b2b_count: got %0d want 2", count); end
  endtask

  task automatic test_imm_range();
    do_req(3'd0, 5'd1, 5'd1, 64'd4096);
    n_cmp++; if (mem_write !== 1'b0) begin n_bad++; $display("FAIL k4096_encode_wr: got %b want 0", mem_write); end
    tick();
    n_cmp++; if (mem_write !== 1'b0 || err !== 1'b1 || count !== 16'd2 || in_ready !== 1'b1) begin n_bad++;
      $display("FAIL k4096: wr %b err %b count %0d ready %b want 0 1 2 1", mem_write, err, count, in_ready); end
    do_req(3'd1, 5'd1, 5'd1, 64'h0001_0000_0000_0005);
    tick();
    n_cmp++; if (mem_write !== 1'b0 || count !== 16'd2) begin n_bad++;
      $display("FAIL k_high_bits: wr %b count %0d want 0 2", mem_write, count); end
    do_req(3'd4, 5'd5, 5'd6, 64'd4095);
    tick();
    n_cmp++; if (mem_write !== 1'b1 || mem_addr !== 64'd8 || mem_data !== 32'h923FFCC5) begin n_bad++;
      $display("FAIL andi_after_err: wr %b addr %h data %h want 1 8 923ffcc5", mem_write, mem_addr, mem_data); end
    tick();
    n_cmp++; if (err !== 1'b1 || count !== 16'd3) begin n_bad++; $display("FAIL err_sticky: err %b count %0d want 1 3", err, count); end
  endtask

  task automatic test_opc_table();
    clear = 1'b1; tick(); clear = 1'b0;
    n_cmp++; if (err !== 1'b0 || count !== 16'd0) begin n_bad++; $display("FAIL clear_err: err %b count %0d want 0 0", err, count); end
    for (int i = 0; i < 8; i++) begin
      do_req(3'(i), 5'd0, 5'd0, 64'd0);
      tick();
      n_cmp++; if (mem_write !== 1'b1 || mem_data !== OPC_W[i] || mem_addr !== 64'(4 * i)) begin n_bad++;
        $display("FAIL opc_%0d: wr %b addr %h data %h want 1 %h %h", i, mem_write, mem_addr, mem_data, 64'(4 * i), OPC_W[i]); end
      tick();
    end
    n_cmp++; if (count !== 16'd8) begin n_bad++; $display("FAIL opc_count: got %0d want 8", count); end
  endtask

  task automatic test_clear_write();
    do_req(3'd2, 5'd9, 5'd10, 64'd7);
    tick();
    clear = 1'b1;
    #1;
    n_cmp++; if (mem_write !== 1'b0) begin n_bad++; $display("FAIL clear_write_strobe: got %b want 0", mem_write); end
    tick();
    clear = 1'b0;
    n_cmp++; if (count !== 16'd0 || in_ready !== 1'b1) begin n_bad++;
      $display("FAIL clear_write_count: count %0d ready %b want 0 1", count, in_ready); end
    do_req(3'd2, 5'd9, 5'd10, 64'd7);
    tick();
    n_cmp++; if (mem_write !== 1'b1 || mem_addr !== 64'd0 || mem_data !== 32'hD1001D49) begin n_bad++;
      $display("FAIL clear_write_next: wr %b addr %h data %h want 1 0 d1001d49", mem_write, mem_addr, mem_data); end
    tick();
  endtask

  task automatic test_full();
    int wr_seen;
    op = 3'd0; rd = 5'd1; rn = 5'd2; k = 64'd5;
    for (int i = 0; i < 2; i++) begin
      n_cmp++; if (in_ready2 !== 1'b1) begin n_bad++; $display("FAIL full_ready_%0d: got %b want 1", i, in_ready2); end
      in_valid2 = 1'b1; tick(); in_valid2 = 1'b0;
      tick();
      n_cmp++; if (mem_write2 !== 1'b1 || mem_addr2 !== 64'(4 * i)) begin n_bad++;
        $display("FAIL full_write_%0d: wr %b addr %h want 1 %h", i, mem_write2, mem_addr2, 64'(4 * i)); end
      tick();
    end
    n_cmp++; if (full2 !== 1'b1 || in_ready2 !== 1'b0 || count2 !== 16'd2) begin n_bad++;
      $display("FAIL full_state: full %b ready %b count %0d want 1 0 2", full2, in_ready2, count2); end
    wr_seen = 0;
    in_valid2 = 1'b1;
    repeat (6) begin tick(); if (mem_write2 === 1'b1) wr_seen++; end
    in_valid2 = 1'b0;
    n_cmp++; if (wr_seen !== 0 || count2 !== 16'd2 || full2 !== 1'b1) begin n_bad++;
      $display("FAIL full_reject: writes %0d count %0d full %b want 0 2 1", wr_seen, count2, full2); end
    clear2 = 1'b1; tick(); clear2 = 1'b0;
    n_cmp++; if (count2 !== 16'd0 || full2 !== 1'b0 || in_ready2 !== 1'b1) begin n_bad++;
      $display("FAIL full_clear: count %0d full %b ready %b want 0 0 1", count2, full2, in_ready2); end
  endtask

  task automatic test_reset_mid();
    int wr_seen;
    do_req(3'd6, 5'd2, 5'd3, 64'd9);
    reset_n = 1'b0;
    #1;
    n_cmp++; if ({in_ready, mem_write, full, err} !== 4'b0000 || mem_addr !== 64'd0 || mem_data !== 32'd0 || count !== 16'd0) begin n_bad++;
      $display("FAIL reset_mid: ready %b wr %b full %b err %b addr %h data %h count %0d want all 0",
               in_ready, mem_write, full, err, mem_addr, mem_data, count); end
    #2;
    reset_n = 1'b1;
    wr_seen = 0;
    repeat (4) begin tick(); if (mem_write === 1'b1) wr_seen++; end
    n_cmp++; if (wr_seen !== 0 || count !== 16'd0 || in_ready !== 1'b1) begin n_bad++;
      $display("FAIL reset_mid_after: writes %0d count %0d ready %b want 0 0 1", wr_seen, count, in_ready); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_clear_idle();
    test_back_to_back();
    test_imm_range();
    test_opc_table();
    test_clear_write();
    test_full();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
